// File: rtl/rs_chien_eval.sv
// Chien search evaluator: evaluates Lambda at the generator's candidate roots and compacts hits.
// Optional RS_CHIEN_EVAL_PIPE_EN adds a register stage between evaluation and compaction.

package gf_pkg;
    localparam int unsigned SYMB_WIDTH             = 8;
    localparam int unsigned N_LEN                  = 255;
    localparam int unsigned T_LEN                  = 8;
    localparam int unsigned ROOTS_PER_CYCLE__CHIEN = 4;
    localparam int unsigned CYCLES_NUM__CHIEN      = 64;
    // Low bits of the primitive polynomial x^8+x^4+x^3+x^2+1
    localparam logic [SYMB_WIDTH-1:0] PRIM_POLY    = 8'h1D;

    function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                       input logic [SYMB_WIDTH-1:0] b);
        logic [SYMB_WIDTH-1:0] acc;
        logic [SYMB_WIDTH-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[SYMB_WIDTH-1] ? ((x << 1) ^ PRIM_POLY) : (x << 1);
        end
        return acc;
    endfunction

    // alpha^e by square-and-multiply over the exponent bits
    function automatic logic [SYMB_WIDTH-1:0] alpha_to_symb(input logic [SYMB_WIDTH-1:0] e);
        logic [SYMB_WIDTH-1:0] acc;
        logic [SYMB_WIDTH-1:0] p;
        acc = SYMB_WIDTH'(1);
        p   = SYMB_WIDTH'(2);
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (e[i]) acc = gf_mult(acc, p);
            p = gf_mult(p, p);
        end
        return acc;
    endfunction
endpackage

module rs_chien_eval #(
    parameter int unsigned SYMB_WIDTH      = gf_pkg::SYMB_WIDTH,
    parameter int unsigned N_LEN           = gf_pkg::N_LEN,
    parameter int unsigned T_LEN           = gf_pkg::T_LEN,
    parameter int unsigned ROOTS_PER_CYCLE = gf_pkg::ROOTS_PER_CYCLE__CHIEN,
    parameter int unsigned CYCLES_NUM      = gf_pkg::CYCLES_NUM__CHIEN
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic                                        lambda_vld,
    input  logic [T_LEN:0][SYMB_WIDTH-1:0]              lambda,
    input  logic [$clog2(T_LEN+1)-1:0]                  lambda_deg,
    output logic                                        busy,
    output logic                                        chien_start,
    input  logic [ROOTS_PER_CYCLE-1:0][SYMB_WIDTH-1:0]  alpha_current,
    input  logic [ROOTS_PER_CYCLE-1:0][SYMB_WIDTH-1:0]  roots,
    input  logic                                        roots_vld,
    output logic [T_LEN-1:0][SYMB_WIDTH-1:0]            err_pos,
    output logic [$clog2(T_LEN+1)-1:0]                  err_num,
    output logic                                        decode_fail,
    output logic                                        done
);

    localparam int unsigned DEG_W  = $clog2(T_LEN + 1);
    localparam int unsigned PROD_W = 2 * SYMB_WIDTH;
    localparam int unsigned GRP_W  = (CYCLES_NUM > 1) ? $clog2(CYCLES_NUM) : 1;

    // FLUSH is only entered when the compaction stage is pipelined
    typedef enum logic [2:0] {IDLE, START, SEARCH, FLUSH, DONE} state_t;

    state_t                                 state, state_nxt;
    logic [T_LEN:0][SYMB_WIDTH-1:0]         lam_q, lam_nxt;
    logic [DEG_W-1:0]                       deg_q, deg_nxt;
    logic [GRP_W-1:0]                       grp_cnt, grp_nxt;
    logic                                   ovf, ovf_nxt;
    logic                                   busy_nxt, chien_start_nxt, done_nxt, decode_fail_nxt;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0]       err_pos_nxt;
    logic [DEG_W-1:0]                       err_num_nxt;

    logic [ROOTS_PER_CYCLE-1:0]                 hit;
    logic                                       cmp_vld;
    logic [ROOTS_PER_CYCLE-1:0]                 cmp_hit;
    logic [ROOTS_PER_CYCLE-1:0][SYMB_WIDTH-1:0] cmp_alpha;

    // Candidate symbols are regenerated from the alpha indices, so the symbol bus is not consumed
    logic unused_roots;
    assign unused_roots = ^roots;

    // Evaluate Lambda at every candidate of the current group
    always_comb begin : eval
        logic [SYMB_WIDTH-1:0] sum;
        logic [PROD_W-1:0]     prod;
        logic [PROD_W-1:0]     ex;
        sum  = '0;
        prod = '0;
        ex   = '0;
        hit  = '0;
        for (int k = 0; k < ROOTS_PER_CYCLE; k++) begin
            sum = '0;
            for (int j = 0; j <= T_LEN; j++) begin
                prod = PROD_W'(alpha_current[k]) * PROD_W'(j);
                ex   = prod % PROD_W'(N_LEN);
                sum  = sum ^ gf_pkg::gf_mult(lam_q[j], gf_pkg::alpha_to_symb(SYMB_WIDTH'(ex)));
            end
            hit[k] = (sum == '0) && (32'(alpha_current[k]) < N_LEN);
        end
    end

`ifdef RS_CHIEN_EVAL_PIPE_EN
    logic                                       pipe_vld;
    logic [ROOTS_PER_CYCLE-1:0]                 hit_q;
    logic [ROOTS_PER_CYCLE-1:0][SYMB_WIDTH-1:0] alpha_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pipe_vld <= 1'b0;
            hit_q    <= '0;
            alpha_q  <= '0;
        end else begin
            pipe_vld <= (state == SEARCH) && roots_vld;
            hit_q    <= hit;
            alpha_q  <= alpha_current;
        end
    end

    assign cmp_vld   = pipe_vld;
    assign cmp_hit   = hit_q;
    assign cmp_alpha = alpha_q;
`else
    assign cmp_vld   = (state == SEARCH) && roots_vld;
    assign cmp_hit   = hit;
    assign cmp_alpha = alpha_current;
`endif

    // Next-state, compaction and output decode
    always_comb begin : fsm
        int unsigned cnt;
        state_nxt       = state;
        lam_nxt         = lam_q;
        deg_nxt         = deg_q;
        grp_nxt         = grp_cnt;
        ovf_nxt         = ovf;
        err_pos_nxt     = err_pos;
        err_num_nxt     = err_num;
        decode_fail_nxt = decode_fail;
        cnt             = 0;

        // Append hits in ascending candidate order; extra hits beyond T_LEN set overflow
        if (cmp_vld) begin
            cnt = 32'(err_num);
            for (int k = 0; k < ROOTS_PER_CYCLE; k++) begin
                if (cmp_hit[k]) begin
                    if (cnt < T_LEN) begin
                        for (int p = 0; p < T_LEN; p++) begin
                            if (32'(p) == cnt) err_pos_nxt[p] = cmp_alpha[k];
                        end
                        cnt = cnt + 1;
                    end else begin
                        ovf_nxt = 1'b1;
                    end
                end
            end
            err_num_nxt = DEG_W'(cnt);
        end

        case (state)
            IDLE: begin
                if (lambda_vld) begin
                    lam_nxt         = lambda;
                    deg_nxt         = lambda_deg;
                    err_num_nxt     = '0;
                    err_pos_nxt     = '0;
                    ovf_nxt         = 1'b0;
                    decode_fail_nxt = 1'b0;
                    state_nxt       = START;
                end
            end
            START: begin
                grp_nxt   = '0;
                state_nxt = SEARCH;
            end
            SEARCH: begin
                if (roots_vld) begin
                    grp_nxt = grp_cnt + GRP_W'(1);
                    if (grp_cnt == GRP_W'(CYCLES_NUM - 1)) begin
`ifdef RS_CHIEN_EVAL_PIPE_EN
                        state_nxt = FLUSH;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy_nxt        = (state_nxt != IDLE);
        chien_start_nxt = (state_nxt == START);
        done_nxt        = (state_nxt == DONE);
        if (state_nxt == DONE) begin
            decode_fail_nxt = ovf_nxt || (err_num_nxt != deg_q);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            lam_q       <= '0;
            deg_q       <= '0;
            grp_cnt     <= '0;
            ovf         <= 1'b0;
            busy        <= 1'b0;
            chien_start <= 1'b0;
            done        <= 1'b0;
            decode_fail <= 1'b0;
            err_pos     <= '0;
            err_num     <= '0;
        end else begin
            state       <= state_nxt;
            lam_q       <= lam_nxt;
            deg_q       <= deg_nxt;
            grp_cnt     <= grp_nxt;
            ovf         <= ovf_nxt;
            busy        <= busy_nxt;
            chien_start <= chien_start_nxt;
            done        <= done_nxt;
            decode_fail <= decode_fail_nxt;
            err_pos     <= err_pos_nxt;
            err_num     <= err_num_nxt;
        end
    end

endmodule
